float_rsqrt_seq: RTL and testbench



---
 rtl/float_rsqrt_pkg.sv | 29 ++
 rtl/float_rsqrt_classify.sv | 41 ++++
 rtl/float_rsqrt_seq.sv | 172 +++++++++++++++++
 tb/tb_float_rsqrt_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/float_rsqrt_pkg.sv
// Shared constants and encodings for the sequential inverse-square-root block.
// 32-bit constants are narrowed at the use site by dropping low bits.
package float_rsqrt_pkg;

  localparam int EXPONENT_SIZE = 8;

  localparam logic [31:0] MAGIC32        = 32'h5F3759DF;
  localparam logic [31:0] THREE_HALVES32 = 32'h3FC00000;
  localparam logic [31:0] QNAN32         = 32'h7FC00000;
  localparam logic [31:0] POS_INF32      = 32'h7F800000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    MULX = 3'd2,
    SUB  = 3'd3,
    MULY = 3'd4,
    DONE = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NORMAL = 3'd0,
    CLS_NEG    = 3'd1,
    CLS_ZERO   = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } cls_e;

endpackage

// File: rtl/float_rsqrt_classify.sv
// Combinational special-case detector: operand class and the result forced for it.
module float_rsqrt_classify
  import float_rsqrt_pkg::*;
#(
  parameter  int MANTISSA_SIZE = 23,
  localparam int FLOAT_SIZE    = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
  input  logic [FLOAT_SIZE-1:0] x,
  output cls_e                  cls,
  output logic [FLOAT_SIZE-1:0] forced
);

  localparam logic [FLOAT_SIZE-1:0] QNAN    = FLOAT_SIZE'(QNAN32 >> (32 - FLOAT_SIZE));
  localparam logic [FLOAT_SIZE-1:0] POS_INF = FLOAT_SIZE'(POS_INF32 >> (32 - FLOAT_SIZE));

  logic [EXPONENT_SIZE-1:0] exp_f;
  logic [MANTISSA_SIZE-1:0] man_f;

  assign exp_f = x[FLOAT_SIZE-2:MANTISSA_SIZE];
  assign man_f = x[MANTISSA_SIZE-1:0];

  // NaN outranks sign; zero/denormal outranks sign so -0 gives +INF
  always_comb begin
    cls    = CLS_NORMAL;
    forced = '0;
    if (exp_f == '1 && man_f != '0) begin
      cls    = CLS_NAN;
      forced = QNAN;
    end else if (exp_f == '0) begin
      cls    = CLS_ZERO;
      forced = POS_INF;
    end else if (x[FLOAT_SIZE-1]) begin
      cls    = CLS_NEG;
      forced = QNAN;
    end else if (exp_f == '1) begin
      cls    = CLS_INF;
      forced = '0;
    end
  end

endmodule

// File: rtl/float_rsqrt_seq.sv
// Sequential 1/sqrt(x): magic-constant seed, then Newton steps on one shared
// multiplier and one subtractor, sequenced by an FSM with valid/ready on both sides.
module float_rsqrt_seq
  import float_rsqrt_pkg::*;
#(
  parameter  int MANTISSA_SIZE = 23,
  parameter  int ITERATIONS    = 2,
  localparam int FLOAT_SIZE    = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [FLOAT_SIZE-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FLOAT_SIZE-1:0] m_data
);

  localparam int M  = MANTISSA_SIZE;
  localparam int FS = FLOAT_SIZE;
  localparam logic [FS-1:0] MAGIC        = FS'(MAGIC32 >> (32 - FS));
  localparam logic [FS-1:0] THREE_HALVES = FS'(THREE_HALVES32 >> (32 - FS));

  // Truncating multiply; zero/denormal operands flush to zero.
  function automatic logic [FS-1:0] fmul(input logic [FS-1:0] a, input logic [FS-1:0] b);
    logic [M:0]     ma, mb;
    logic [2*M+1:0] p;
    logic [M-1:0]   mf;
    logic           sgn;
    int             e;
    sgn = a[FS-1] ^ b[FS-1];
    ma  = {|a[FS-2:M], a[M-1:0]};
    mb  = {|b[FS-2:M], b[M-1:0]};
    p   = {{(M+1){1'b0}}, ma} * {{(M+1){1'b0}}, mb};
    e   = int'(a[FS-2:M]) + int'(b[FS-2:M]) - 127;
    if (p[2*M+1]) begin
      mf = M'(p >> (M + 1));
      e  = e + 1;
    end else begin
      mf = M'(p >> M);
    end
    if (a[FS-2:M] == '0 || b[FS-2:M] == '0 || e <= 0) fmul = {sgn, {(FS-1){1'b0}}};
    else if (e >= 255)                                 fmul = {sgn, {EXPONENT_SIZE{1'b1}}, {M{1'b0}}};
    else                                               fmul = {sgn, 8'(e), mf};
  endfunction

  // a - b for like-signed operands, three guard bits, truncating.
  function automatic logic [FS-1:0] fsub(input logic [FS-1:0] a, input logic [FS-1:0] b);
    logic [FS-2:0] big, sml;
    logic [M+3:0]  mb, ms, d, n;
    logic [7:0]    ed;
    logic          swap, sgn;
    int unsigned   pos;
    int            e;
    swap = b[FS-2:0] > a[FS-2:0];
    big  = swap ? b[FS-2:0] : a[FS-2:0];
    sml  = swap ? a[FS-2:0] : b[FS-2:0];
    sgn  = swap ? ~b[FS-1] : a[FS-1];
    mb   = {|big[FS-2:M], big[M-1:0], 3'b000};
    ms   = {|sml[FS-2:M], sml[M-1:0], 3'b000};
    ed   = big[FS-2:M] - sml[FS-2:M];
    ms   = (ed > 8'(M + 3)) ? '0 : (ms >> ed);
    d    = mb - ms;
    pos  = 0;
    for (int unsigned i = 0; i < M + 4; i++) if (d[i]) pos = i;
    e    = int'(big[FS-2:M]) - (M + 3) + int'(pos);
    n    = d << (M + 3 - pos);
    if (d == '0 || e <= 0) fsub = '0;
    else                   fsub = {sgn, 8'(e), M'(n >> 3)};
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    iter_q, iter_d;
  logic [FS-1:0] y_q, y_d, t_q, t_d, xh_q, xh_d;
  cls_e          cls_q, cls_d, cls_in;
  logic [FS-1:0] forced_q, forced_d, forced_in;
  logic          s_ready_q, s_ready_d, m_valid_q, m_valid_d;
  logic [FS-1:0] m_data_q, m_data_d;
  logic [FS-1:0] mul_a, mul_b, mul_p, sub_r;

  float_rsqrt_classify #(.MANTISSA_SIZE(MANTISSA_SIZE)) u_classify (
    .x      (s_data),
    .cls    (cls_in),
    .forced (forced_in)
  );

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      SQ:      begin mul_a = y_q;  mul_b = y_q; end
      MULX:    begin mul_a = xh_q; mul_b = t_q; end
      MULY:    begin mul_a = y_q;  mul_b = t_q; end
      default: ;
    endcase
  end

  assign mul_p = fmul(mul_a, mul_b);
  assign sub_r = fsub(THREE_HALVES, t_q);

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    y_d       = y_q;
    t_d       = t_q;
    xh_d      = xh_q;
    cls_d     = cls_q;
    forced_d  = forced_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    case (state_q)
      IDLE: if (s_valid && s_ready_q) begin
        cls_d    = cls_in;
        forced_d = forced_in;
        y_d      = {1'b0, MAGIC[FS-2:0] - {1'b0, s_data[FS-2:1]}};
        xh_d     = {s_data[FS-1], s_data[FS-2:M] - 8'd1, s_data[M-1:0]};
        iter_d   = '0;
        state_d  = SQ;
      end
      SQ:   begin t_d = mul_p; state_d = MULX; end
      MULX: begin t_d = mul_p; state_d = SUB;  end
      SUB:  begin t_d = sub_r; state_d = MULY; end
      MULY: begin
        y_d     = mul_p;
        iter_d  = iter_q + 2'd1;
        state_d = (iter_q == 2'(ITERATIONS - 1)) ? DONE : SQ;
      end
      // First DONE cycle publishes the result; it is then held until taken.
      DONE: if (!m_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = (cls_q == CLS_NORMAL) ? {1'b0, y_q[FS-2:0]} : forced_q;
      end else if (m_ready) begin
        m_valid_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    s_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      iter_q    <= '0;
      y_q       <= '0;
      t_q       <= '0;
      xh_q      <= '0;
      cls_q     <= CLS_NORMAL;
      forced_q  <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      y_q       <= y_d;
      t_q       <= t_d;
      xh_q      <= xh_d;
      cls_q     <= cls_d;
      forced_q  <= forced_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_float_rsqrt_seq.sv
// Directed bench for float_rsqrt_seq: latency, backpressure, specials, reset, accuracy.
module tb_float_rsqrt_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [31:0] s_data, m_data;
  logic        u1_s_valid, u1_s_ready, u1_m_valid, u1_m_ready;
  logic [31:0] u1_s_data, u1_m_data;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  float_rsqrt_seq #(.MANTISSA_SIZE(23), .ITERATIONS(2)) dut (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  float_rsqrt_seq #(.MANTISSA_SIZE(23), .ITERATIONS(1)) dut1 (
    .clk(clk), .resetn(resetn),
    .s_valid(u1_s_valid), .s_ready(u1_s_ready), .s_data(u1_s_data),
    .m_valid(u1_m_valid), .m_ready(u1_m_ready), .m_data(u1_m_data)
  );

  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    v = 1.0 + $itor({9'd0, b[22:0]}) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic real rel_err(input logic [31:0] got, input real expv);
    real d;
    d = (f2r(got) - expv) / expv;
    return (d < 0.0) ? -d : d;
  endfunction

  // Stimulus only: present x, then count cycles until m_valid (0 if it never comes).
  task automatic send(input logic [31:0] x, input logic hold_valid,
                      output int lat, output logic [31:0] res, output int busy_ready);
    lat = 0; res = '0; busy_ready = 0;
    s_valid = 1'b1;
    s_data  = x;
    @(posedge clk); #1;
    if (!hold_valid) s_valid = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      s_data = $urandom;
      @(posedge clk); #1;
      if (m_valid) begin
        lat = j;
        res = m_data;
        break;
      end
      if (s_ready) busy_ready++;
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    u1_s_valid = 1'b0; u1_s_data = '0; u1_m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: s_ready=%b m_valid=%b m_data=%h required 1 0 00000000", s_ready, m_valid, m_data);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || u1_s_ready !== 1'b1 || u1_m_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: s_ready=%b m_valid=%b u1_s_ready=%b u1_m_valid=%b", s_ready, m_valid, u1_s_ready, u1_m_valid);
    end
  endtask

  task automatic test_four();
    int lat, busy;
    logic [31:0] res;
    m_ready = 1'b1;
    send(32'h40800000, 1'b0, lat, res, busy);
    checks++;
    if (lat != 9) begin failures++; $display("FAIL four_latency: got %0d required 9", lat); end
    checks++;
    if (busy != 0) begin failures++; $display("FAIL four_s_ready_busy: s_ready high %0d cycles required 0", busy); end
    checks++;
    if (rel_err(res, 0.5) > 1e-5) begin failures++; $display("FAIL four_value: got %h required ~3f000000", res); end
    @(posedge clk); #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL four_handshake: m_valid=%b s_ready=%b required 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat, busy;
    logic [31:0] res;
    m_ready = 1'b0;
    send(32'h40000000, 1'b0, lat, res, busy);
    checks++;
    if (lat != 9) begin failures++; $display("FAIL bp_latency: got %0d required 9", lat); end
    checks++;
    if (rel_err(res, 0.70710678118654752) > 1e-5) begin failures++; $display("FAIL bp_value: got %h required ~3f3504f3", res); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== res || s_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: m_valid=%b m_data=%h s_ready=%b required 1 %h 0", c, m_valid, m_data, s_ready, res);
      end
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: m_valid=%b s_ready=%b required 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_specials();
    logic [31:0] xs   [4] = '{32'hBF800000, 32'h00000000, 32'h7F800000, 32'h7FC00001};
    logic [31:0] exps [4] = '{32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7FC00000};
    int lat, busy;
    logic [31:0] res;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(xs[i], 1'b0, lat, res, busy);
      checks++;
      if (lat != 9 || res !== exps[i]) begin
        failures++;
        $display("FAIL special %h: got %h after %0d cycles required %h after 9", xs[i], res, lat, exps[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    int lat, busy, pulses;
    logic [31:0] res;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h41100000;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL midop_reset: m_valid=%b s_ready=%b required 0 1", m_valid, s_ready);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (m_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL midop_no_pulse: m_valid seen %0d cycles required 0", pulses); end
    send(32'h41100000, 1'b0, lat, res, busy);
    checks++;
    if (lat != 9 || rel_err(res, 1.0 / 3.0) > 1e-5) begin
      failures++;
      $display("FAIL midop_resume: got %h after %0d cycles required ~3eaaaaab after 9", res, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_iter1();
    int lat;
    logic [31:0] res;
    lat = 0; res = '0;
    u1_m_ready = 1'b1;
    u1_s_valid = 1'b1;
    u1_s_data  = 32'h42C80000;
    @(posedge clk); #1;
    u1_s_valid = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); #1;
      if (u1_m_valid) begin lat = j; res = u1_m_data; break; end
    end
    checks++;
    if (lat != 5) begin failures++; $display("FAIL iter1_latency: got %0d required 5", lat); end
    checks++;
    if (rel_err(res, 0.1) > 2e-3) begin failures++; $display("FAIL iter1_value: got %h required ~0.1 within 2e-3", res); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, busy;
    logic [31:0] x, res;
    logic [7:0]  e;
    real         expv;
    m_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      e    = 8'($urandom_range(230, 20));
      x    = {1'b0, e, 23'($urandom)};
      expv = 1.0 / $sqrt(f2r(x));
      send(x, 1'b1, lat, res, busy);
      checks++;
      if (lat != 9 || busy != 0 || rel_err(res, expv) > 1e-5) begin
        failures++;
        $display("FAIL random x=%h: got %h lat=%0d busy_ready=%0d required %e lat=9", x, res, lat, busy, expv);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_four();
    test_backpressure();
    test_specials();
    test_reset_midop();
    test_iter1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
